marc_processor: RTL and testbench

- 16-bit multi-cycle load/store processor core (mARC) that talks directly to main memory.
- Fetches one 16-bit instruction per instruction cycle from `dataIn`.
- Contains the register file, ALU, PC, IR and control FSM.
- `busA` provides the memory address; `busB` provides store data; `rw` flags writes.

---
 rtl/marc_processor.sv | 163 ++++++++++++++++
 tb/tb_marc_processor.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/marc_processor.sv
// mARC 16-bit multi-cycle load/store core: FETCH -> EXEC (-> MEM for LD/ST).
// Talks directly to main memory through busA (address), busB (store data) and rw.
module marc_processor #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dataIn,
    output logic [15:0] busA,
    output logic [15:0] busB,
    output logic        rw
);

    typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] regs [8];
    logic        z;
    logic        n;

    logic [1:0]  op;
    logic [2:0]  op3;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [7:0]  imm8;
    logic [15:0] imm_ext;
    logic [15:0] rs1_val;
    logic [15:0] rs2_val;
    logic [15:0] rd_val;

    assign op      = ir[15:14];
    assign op3     = ir[13:11];
    assign rd      = ir[10:8];
    assign rs1     = ir[7:5];
    assign rs2     = ir[4:2];
    assign imm8    = ir[7:0];
    assign imm_ext = {{8{imm8[7]}}, imm8};
    assign rs1_val = (rs1 == 3'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 3'd0) ? '0 : regs[rs2];
    assign rd_val  = (rd == 3'd0) ? '0 : regs[rd];

    logic [15:0] alu_res;
    logic [15:0] wr_data;
    logic        wr_en;
    logic        flag_en;
    logic        is_mem;
    logic        taken;

    always_comb begin
        alu_res = '0;
        case (op3)
            3'b000:  alu_res = rs1_val + rs2_val;
            3'b001:  alu_res = rs1_val - rs2_val;
            3'b010:  alu_res = rs1_val & rs2_val;
            3'b011:  alu_res = rs1_val | rs2_val;
            3'b100:  alu_res = rs1_val ^ rs2_val;
            3'b101:  alu_res = rs1_val << rs2_val[3:0];
            3'b110:  alu_res = rs1_val >> rs2_val[3:0];
            default: alu_res = '0;
        endcase
    end

    // Writeback decode for everything that completes in EXEC; flags follow the written result.
    always_comb begin
        wr_data = '0;
        wr_en   = 1'b0;
        flag_en = 1'b0;
        case (op)
            2'b00: begin
                if (op3 != 3'b111) begin
                    wr_data = alu_res;
                    wr_en   = 1'b1;
                    flag_en = 1'b1;
                end
            end
            2'b01: begin
                case (op3)
                    3'b000: begin
                        wr_data = rd_val + imm_ext;
                        wr_en   = 1'b1;
                        flag_en = 1'b1;
                    end
                    3'b010: begin
                        wr_data = {8'h00, imm8};
                        wr_en   = 1'b1;
                    end
                    3'b011: begin
                        wr_data = {imm8, rd_val[7:0]};
                        wr_en   = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        is_mem = (op == 2'b10) && (op3 == 3'b000 || op3 == 3'b001);
        taken  = 1'b0;
        if (op == 2'b11) begin
            case (op3)
                3'b000:  taken = 1'b1;
                3'b001:  taken = z;
                3'b010:  taken = ~z;
                3'b011:  taken = n;
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            z     <= 1'b0;
            n     <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                FETCH: begin
                    ir    <= dataIn;
                    state <= EXEC;
                end
                EXEC: begin
                    if (wr_en && rd != 3'd0) begin
                        regs[rd] <= wr_data;
                    end
                    if (flag_en) begin
                        z <= (wr_data == 16'h0000);
                        n <= wr_data[15];
                    end
                    if (is_mem) begin
                        state <= MEM;
                    end else begin
                        state <= FETCH;
                        pc    <= taken ? pc + imm_ext : pc + 16'd1;
                    end
                end
                MEM: begin
                    if (op3 == 3'b000 && rd != 3'd0) begin
                        regs[rd] <= dataIn;
                    end
                    pc    <= pc + 16'd1;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    // MEM is entered only for LD/ST, so op3 alone tells a store apart.
    assign busA = (state == FETCH) ? pc : rs1_val;
    assign busB = (state == MEM) ? rd_val : rs2_val;
    assign rw   = (state == MEM) && (op3 == 3'b001);

endmodule

// File: tb/tb_marc_processor.sv
// Scoreboard bench for marc_processor: an instruction-level reference model
// predicts busA/busB/rw for every cycle; a negedge monitor pops and compares.
module tb_marc_processor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dataIn;
    logic [15:0] busA;
    logic [15:0] busB;
    logic        rw;

    logic [15:0] mem [65536];

    marc_processor #(.RESET_PC(16'h0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .dataIn (dataIn),
        .busA   (busA),
        .busB   (busB),
        .rw     (rw)
    );

    always #5 clk = ~clk;

    // Main memory is read-only from the core's point of view; stores are only observed.
    assign dataIn = mem[busA];

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        w;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   phase = 0;
    logic active = 1'b0;

    logic [15:0] ref_r [8];
    logic [15:0] ref_pc;
    logic        ref_z;
    logic        ref_n;
    logic [2:0]  ref_prs2;
    int          ref_cyc;

    task automatic chk(input string name, input int cyc, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s phase=%0d cycle=%0d got=%h expected=%h", name, phase, cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (active && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("busA", e.cyc, busA, e.a);
            chk("busB", e.cyc, busB, e.b);
            chk("rw", e.cyc, {15'd0, rw}, {15'd0, e.w});
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic w);
        exp_t e;
        e.a = a;
        e.b = b;
        e.w = w;
        e.cyc = ref_cyc;
        ref_cyc++;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        ref_pc   = 16'h0000;
        ref_z    = 1'b0;
        ref_n    = 1'b0;
        ref_prs2 = 3'd0;
    endtask

    task automatic set_reg(input logic [2:0] d, input logic [15:0] v);
        if (d != 3'd0) ref_r[d] = v;
    endtask

    task automatic set_flags(input logic [15:0] v);
        ref_z = (v == 16'h0000);
        ref_n = v[15];
    endtask

    // Executes one instruction and predicts the bus values of each of its cycles.
    task automatic model_step();
        logic [15:0] ir, a, b, res, imm, nxt;
        logic [1:0]  op;
        logic [2:0]  f3, d, s1, s2;
        bit          tk;
        ir  = mem[ref_pc];
        push(ref_pc, ref_r[ref_prs2], 1'b0);
        op  = ir[15:14];
        f3  = ir[13:11];
        d   = ir[10:8];
        s1  = ir[7:5];
        s2  = ir[4:2];
        a   = ref_r[s1];
        b   = ref_r[s2];
        imm = {{8{ir[7]}}, ir[7:0]};
        push(a, b, 1'b0);
        nxt = ref_pc + 16'd1;
        case (op)
            2'd0: if (f3 != 3'd7) begin
                case (f3)
                    3'd0: res = a + b;
                    3'd1: res = a - b;
                    3'd2: res = a & b;
                    3'd3: res = a | b;
                    3'd4: res = a ^ b;
                    3'd5: res = a << b[3:0];
                    default: res = a >> b[3:0];
                endcase
                set_reg(d, res);
                set_flags(res);
            end
            2'd1: begin
                if (f3 == 3'd0) begin
                    res = ref_r[d] + imm;
                    set_reg(d, res);
                    set_flags(res);
                end else if (f3 == 3'd2) begin
                    set_reg(d, {8'h00, ir[7:0]});
                end else if (f3 == 3'd3) begin
                    set_reg(d, {ir[7:0], ref_r[d][7:0]});
                end
            end
            2'd2: if (f3 == 3'd0 || f3 == 3'd1) begin
                push(a, ref_r[d], f3 == 3'd1);
                if (f3 == 3'd0) set_reg(d, mem[a]);
            end
            default: begin
                tk = (f3 == 3'd0) || (f3 == 3'd1 && ref_z) || (f3 == 3'd2 && !ref_z) || (f3 == 3'd3 && ref_n);
                if (tk) nxt = ref_pc + imm;
            end
        endcase
        ref_pc   = nxt;
        ref_prs2 = s2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    endtask

    task automatic begin_run(input int n_instr);
        phase++;
        ref_cyc = 0;
        model_reset();
        for (int i = 0; i < n_instr; i++) model_step();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        active = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout phase=%0d got=%0d pending expected=0", phase, exp_q.size());
            exp_q.delete();
        end
        active = 1'b0;
    endtask

    initial begin
        // setlow/sethi into r1/r2 then store both through [r0]
        clear_mem();
        mem[0] = 16'h5140; mem[1] = 16'h5A01; mem[2] = 16'h8900; mem[3] = 16'h8A00;
        begin_run(4);
        drain();

        // sethi keeps the low byte
        clear_mem();
        mem[0] = 16'h53FF; mem[1] = 16'h5B12; mem[2] = 16'h8B00;
        begin_run(3);
        drain();

        // add/sub, taken BE skips two instructions, BNE on same flags falls through
        clear_mem();
        mem[0] = 16'h5105; mem[1] = 16'h5205; mem[2] = 16'h0428; mem[3] = 16'h0B28;
        mem[4] = 16'hC803; mem[5] = 16'h5677; mem[6] = 16'h5677; mem[7] = 16'hD003;
        mem[8] = 16'h8C00; mem[9] = 16'h8B00;
        begin_run(8);
        drain();

        // ld then st of the loaded word
        clear_mem();
        mem[0] = 16'h5120; mem[1] = 16'h8420; mem[2] = 16'h8C20; mem[16'h20] = 16'hBEEF;
        begin_run(3);
        drain();

        // writes to r0 are discarded
        clear_mem();
        mem[0] = 16'h5007; mem[1] = 16'h8800;
        begin_run(2);
        drain();

        // reset during the MEM cycle of a store restarts cleanly from address 0
        clear_mem();
        mem[0] = 16'h5155; mem[1] = 16'h8900;
        begin_run(2);
        model_reset();
        for (int i = 0; i < 2; i++) model_step();
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        drain();

        // random programs over a fully random memory image
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
            begin_run(60);
            drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
